// File: rtl/bt_pipe_out_streamer_if.sv
// Stream/endpoint bundle between user logic, the okBTPipeOut endpoint and the
// pipe-out streamer.
interface bt_pipe_out_streamer_if #(
    parameter int DEPTH_LOG2 = 9
);
    logic [31:0]         s_data;
    logic                s_valid;
    logic                s_ready;
    logic                ep_read;
    logic                ep_blockstrobe;
    logic                ep_ready;
    logic [31:0]         ep_datain;
    logic [DEPTH_LOG2:0] level;
    logic                underrun;
    logic                proto_err;

    modport master (
        output s_data, s_valid, ep_read, ep_blockstrobe,
        input  s_ready, ep_ready, ep_datain, level, underrun, proto_err
    );

    modport slave (
        input  s_data, s_valid, ep_read, ep_blockstrobe,
        output s_ready, ep_ready, ep_datain, level, underrun, proto_err
    );
endinterface

// File: rtl/bt_pipe_out_streamer.sv
// Device-to-host buffer for a block-throttled pipe-out: a word FIFO that
// advertises ep_ready only once a full host block is buffered.
module bt_pipe_out_streamer #(
    parameter int DEPTH_LOG2  = 9,
    parameter int BLOCK_WORDS = 16
) (
    input logic                   okClk,
    input logic                   rst,
    input logic                   clear,
    bt_pipe_out_streamer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_C  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   BLOCK_C = (DEPTH_LOG2+1)'(BLOCK_WORDS);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO_C = (DEPTH_LOG2+1)'(0);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE_C  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO_C = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE_C  = DEPTH_LOG2'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    logic [31:0]           mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   count_next_s;
    logic [DEPTH_LOG2:0]   rem_r;
    logic [DEPTH_LOG2:0]   rem_next_s;
    state_t                state_r;
    state_t                state_next_s;
    logic                  ep_ready_r;
    logic                  ep_ready_next_s;
    logic [31:0]           ep_datain_r;
    logic                  underrun_r;
    logic                  proto_err_r;
    logic                  s_ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  underrun_set_s;
    logic                  proto_set_s;

    assign s_ready_s      = (count_r != FULL_C);
    assign push_s         = bus.s_valid & s_ready_s;
    assign pop_s          = bus.ep_read & (count_r != CNT_ZERO_C);
    assign underrun_set_s = bus.ep_read & (count_r == CNT_ZERO_C);

    assign bus.s_ready   = s_ready_s;
    assign bus.ep_ready  = ep_ready_r;
    assign bus.ep_datain = ep_datain_r;
    assign bus.level     = count_r;
    assign bus.underrun  = underrun_r;
    assign bus.proto_err = proto_err_r;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE_C;
            2'b01:   count_next_s = count_r - CNT_ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // Block-tracking FSM next state; a read in IDLE is still serviced but flagged.
    always_comb begin
        state_next_s = state_r;
        rem_next_s   = rem_r;
        proto_set_s  = 1'b0;
        case (state_r)
            IDLE: begin
                proto_set_s = bus.ep_read;
                if (bus.ep_blockstrobe) begin
                    state_next_s = XFER;
                    rem_next_s   = BLOCK_C;
                end else begin
                    state_next_s = IDLE;
                end
            end
            XFER: begin
                if (bus.ep_blockstrobe) begin
                    proto_set_s = 1'b1;
                    rem_next_s  = BLOCK_C;
                end else if (bus.ep_read) begin
                    rem_next_s = rem_r - CNT_ONE_C;
                    if (rem_r == CNT_ONE_C) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = XFER;
                    end
                end else begin
                    state_next_s = XFER;
                end
            end
            default: begin
                state_next_s = IDLE;
                rem_next_s   = CNT_ZERO_C;
            end
        endcase
        ep_ready_next_s = (state_next_s == IDLE) && (count_next_s >= BLOCK_C);
    end

    // FIFO storage; contents are never reset.
    always_ff @(posedge okClk) begin
        if (push_s && !clear && !rst) begin
            mem_r[wr_ptr_r] <= bus.s_data;
        end
    end

    // Pointers, count, FSM and registered endpoint outputs.
    always_ff @(posedge okClk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= PTR_ZERO_C;
            rd_ptr_r    <= PTR_ZERO_C;
            count_r     <= CNT_ZERO_C;
            rem_r       <= CNT_ZERO_C;
            state_r     <= IDLE;
            ep_ready_r  <= 1'b0;
            ep_datain_r <= 32'h0000_0000;
            underrun_r  <= 1'b0;
            proto_err_r <= 1'b0;
        end else if (clear) begin
            wr_ptr_r    <= PTR_ZERO_C;
            rd_ptr_r    <= PTR_ZERO_C;
            count_r     <= CNT_ZERO_C;
            rem_r       <= CNT_ZERO_C;
            state_r     <= IDLE;
            ep_ready_r  <= 1'b0;
            ep_datain_r <= 32'h0000_0000;
            underrun_r  <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r    <= rd_ptr_r + PTR_ONE_C;
                ep_datain_r <= mem_r[rd_ptr_r];
            end else if (underrun_set_s) begin
                ep_datain_r <= 32'h0000_0000;
            end
            count_r     <= count_next_s;
            rem_r       <= rem_next_s;
            state_r     <= state_next_s;
            ep_ready_r  <= ep_ready_next_s;
            underrun_r  <= underrun_r | underrun_set_s;
            proto_err_r <= proto_err_r | proto_set_s;
        end
    end
endmodule

// File: tb/tb_bt_pipe_out_streamer.sv
// Directed self-checking bench for bt_pipe_out_streamer.
module tb_bt_pipe_out_streamer;
    logic okClk;
    logic rst;
    logic clear;
    int   checks;
    int   failures;

    bt_pipe_out_streamer_if #(.DEPTH_LOG2(9)) bus ();

    bt_pipe_out_streamer #(
        .DEPTH_LOG2 (9),
        .BLOCK_WORDS(16)
    ) dut (
        .okClk(okClk),
        .rst  (rst),
        .clear(clear),
        .bus  (bus.slave)
    );

    initial okClk = 1'b0;
    always #5 okClk = ~okClk;

    task automatic tick();
        @(posedge okClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear    = 1'b0;
        bus.s_data         = 32'h0;
        bus.s_valid        = 1'b0;
        bus.ep_read        = 1'b0;
        bus.ep_blockstrobe = 1'b0;
        tick();
        tick();
        chk("rst_ep_ready", 32'(bus.ep_ready), 32'd0);
        chk("rst_datain", bus.ep_datain, 32'h0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_underrun", 32'(bus.underrun), 32'd0);
        chk("rst_proto", 32'(bus.proto_err), 32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Basic block: 16 pushes, strobe, 16 reads.
        for (int i = 0; i < 16; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'h100 + 32'(i);
            tick();
            chk("fill_level", 32'(bus.level), 32'(i + 1));
            chk("fill_ep_ready", 32'(bus.ep_ready), (i == 15) ? 32'd1 : 32'd0);
        end
        bus.s_valid = 1'b0;
        bus.ep_blockstrobe = 1'b1;
        tick();
        bus.ep_blockstrobe = 1'b0;
        chk("strobe_ep_ready", 32'(bus.ep_ready), 32'd0);
        for (int i = 0; i < 16; i++) begin
            bus.ep_read = 1'b1;
            tick();
            chk("blk_data", bus.ep_datain, 32'h100 + 32'(i));
            chk("blk_ep_ready", 32'(bus.ep_ready), 32'd0);
        end
        bus.ep_read = 1'b0;
        chk("blk_level", 32'(bus.level), 32'd0);
        chk("blk_proto", 32'(bus.proto_err), 32'd0);
        chk("blk_underrun", 32'(bus.underrun), 32'd0);
        tick();
        chk("blk_hold", bus.ep_datain, 32'h10F);

        // Fill to 512, then attempt a 513th push.
        bus.s_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            bus.s_data = 32'h2000 + 32'(i);
            tick();
        end
        chk("full_level", 32'(bus.level), 32'd512);
        chk("full_s_ready", 32'(bus.s_ready), 32'd0);
        bus.s_data = 32'hDEAD;
        tick();
        chk("full_no_push", 32'(bus.level), 32'd512);
        chk("full_ep_ready", 32'(bus.ep_ready), 32'd1);
        bus.s_valid = 1'b0;
        bus.ep_blockstrobe = 1'b1;
        tick();
        bus.ep_blockstrobe = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.ep_read = 1'b1;
            tick();
            chk("full_data", bus.ep_datain, 32'h2000 + 32'(i));
            if (i == 0) begin
                chk("full_s_ready_after_pop", 32'(bus.s_ready), 32'd1);
                chk("full_level_after_pop", 32'(bus.level), 32'd511);
            end
        end
        bus.ep_read = 1'b0;
        chk("full_ep_ready_reassert", 32'(bus.ep_ready), 32'd1);
        chk("full_level_end", 32'(bus.level), 32'd496);

        // Steady push during reads; read pointer wraps 511 -> 0 after 480 reads.
        for (int b = 0; b < 31; b++) begin
            bus.ep_blockstrobe = 1'b1;
            tick();
            bus.ep_blockstrobe = 1'b0;
            for (int j = 0; j < 16; j++) begin
                bus.ep_read = 1'b1;
                bus.s_valid = 1'b1;
                bus.s_data  = 32'h3000 + 32'(b * 16 + j);
                tick();
                chk("steady_data", bus.ep_datain, 32'h2010 + 32'(b * 16 + j));
            end
            bus.ep_read = 1'b0;
            bus.s_valid = 1'b0;
            chk("steady_level", 32'(bus.level), 32'd496);
            chk("steady_ep_ready", 32'(bus.ep_ready), 32'd1);
        end
        chk("steady_proto", 32'(bus.proto_err), 32'd0);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr1_level", 32'(bus.level), 32'd0);
        chk("clr1_ep_ready", 32'(bus.ep_ready), 32'd0);
        chk("clr1_datain", bus.ep_datain, 32'h0);

        // Short block: 3 words, 5 reads.
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'h40 + 32'(i);
            tick();
        end
        bus.s_valid = 1'b0;
        chk("short_ep_ready", 32'(bus.ep_ready), 32'd0);
        bus.ep_blockstrobe = 1'b1;
        tick();
        bus.ep_blockstrobe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.ep_read = 1'b1;
            tick();
            chk("short_data", bus.ep_datain, (i < 3) ? 32'h40 + 32'(i) : 32'h0);
            chk("short_underrun", 32'(bus.underrun), (i < 3) ? 32'd0 : 32'd1);
        end
        bus.ep_read = 1'b0;
        chk("short_level", 32'(bus.level), 32'd0);
        chk("short_proto", 32'(bus.proto_err), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr2_underrun", 32'(bus.underrun), 32'd0);

        // Read outside a block, then strobe during a block, then clear with a push.
        for (int i = 0; i < 2; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'h50 + 32'(i);
            tick();
        end
        bus.s_valid = 1'b0;
        bus.ep_read = 1'b1;
        tick();
        bus.ep_read = 1'b0;
        chk("idle_read_data", bus.ep_datain, 32'h50);
        chk("idle_read_proto", 32'(bus.proto_err), 32'd1);
        chk("idle_read_level", 32'(bus.level), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr3_proto", 32'(bus.proto_err), 32'd0);
        bus.ep_blockstrobe = 1'b1;
        tick();
        chk("strobe_xfer_proto0", 32'(bus.proto_err), 32'd0);
        tick();
        bus.ep_blockstrobe = 1'b0;
        chk("strobe_xfer_proto1", 32'(bus.proto_err), 32'd1);
        clear = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h77;
        tick();
        clear = 1'b0;
        bus.s_valid = 1'b0;
        chk("clr4_level", 32'(bus.level), 32'd0);
        chk("clr4_proto", 32'(bus.proto_err), 32'd0);
        chk("clr4_underrun", 32'(bus.underrun), 32'd0);
        chk("clr4_ep_ready", 32'(bus.ep_ready), 32'd0);
        chk("clr4_datain", bus.ep_datain, 32'h0);

        // Async reset mid-block, then a fresh block.
        for (int i = 0; i < 16; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'h600 + 32'(i);
            tick();
        end
        bus.s_valid = 1'b0;
        bus.ep_blockstrobe = 1'b1;
        tick();
        bus.ep_blockstrobe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.ep_read = 1'b1;
            tick();
            chk("pre_rst_data", bus.ep_datain, 32'h600 + 32'(i));
        end
        bus.ep_read = 1'b0;
        rst = 1'b1;
        #2;
        chk("arst_datain", bus.ep_datain, 32'h0);
        chk("arst_level", 32'(bus.level), 32'd0);
        chk("arst_ep_ready", 32'(bus.ep_ready), 32'd0);
        chk("arst_s_ready", 32'(bus.s_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'h700 + 32'(i);
            tick();
        end
        bus.s_valid = 1'b0;
        chk("post_rst_ep_ready", 32'(bus.ep_ready), 32'd1);
        bus.ep_blockstrobe = 1'b1;
        tick();
        bus.ep_blockstrobe = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.ep_read = 1'b1;
            tick();
            chk("post_rst_data", bus.ep_datain, 32'h700 + 32'(i));
        end
        bus.ep_read = 1'b0;
        chk("post_rst_level", 32'(bus.level), 32'd0);
        chk("post_rst_proto", 32'(bus.proto_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bt_pipe_out_streamer.md
# bt_pipe_out_streamer

Transmit-side buffer that feeds a block-throttled FrontPanel pipe-out endpoint (okBTPipeOut) from a user-logic valid/ready word stream. It is the device-to-host counterpart of the pipe-in capture path. User logic pushes 32-bit words into an internal FIFO, and the block raises `ep_ready` only when a full host block is buffered. Host-issued `ep_read` strobes pop words onto `ep_datain` with the endpoint's one-cycle read latency.

## Interface
- `DEPTH_LOG2`, 9: FIFO depth is 2^DEPTH_LOG2 32-bit words (512).
- `BLOCK_WORDS`, 16: host block length in 32-bit words; 1 ≤ BLOCK_WORDS ≤ 2^DEPTH_LOG2.
- `okClk`  in  1  sole clock, FrontPanel host-interface clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `clear`  in  1  synchronous flush (driven from a wire-in bit), active-high.
- `s_data`  in  32  user word.
- `s_valid`  in  1  user word valid.
- `s_ready`  out  1  FIFO can accept a word this cycle.
- `ep_read`  in  1  okBTPipeOut read strobe.
- `ep_blockstrobe`  in  1  okBTPipeOut block-start strobe.
- `ep_ready`  out  1  a full block is available to the host.
- `ep_datain`  out  32  word presented to okBTPipeOut.
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy in words.
- `underrun`  out  1  sticky: `ep_read` while FIFO empty.
- `proto_err`  out  1  sticky: `ep_read` outside a block, or `ep_blockstrobe` during a block.

## Operation
- FIFO: dual-pointer RAM, DEPTH_LOG2-bit pointers wrapping modulo depth, separate (DEPTH_LOG2+1)-bit count register; `level` = count.
- Push occurs when `s_valid & s_ready`; `s_ready` = (count != 2^DEPTH_LOG2), combinational from the registered count.
- Pop occurs when `ep_read` and count ≠ 0.
  - On a pop, `ep_datain` loads the head word at that edge.
  - Otherwise `ep_datain` holds its value.
- `ep_read` with count = 0:
  - `ep_datain` loads 0.
  - Pointers and count are unchanged.
  - `underrun` sets.
- Simultaneous push and pop: both execute and count is unchanged; legal at full (pop frees the slot only on the next cycle, so `s_ready` stays 0 that cycle) and at empty+push (no pop, underrun).
- FSM states: IDLE, XFER.
  - IDLE -> XFER on `ep_blockstrobe`; the remaining-word counter loads BLOCK_WORDS.
  - In XFER, each `ep_read` decrements the counter; the read that takes it to 0 returns to IDLE.
  - `ep_read` in IDLE is still serviced (pop or underrun) and sets `proto_err`.
  - `ep_blockstrobe` in XFER sets `proto_err` and reloads the counter to BLOCK_WORDS.
- `ep_ready` is a register: next value = (state_next == IDLE) & (count_next ≥ BLOCK_WORDS); it is forced 0 throughout XFER.
- `clear` (when `rst` is low):
  - Pointers, count, `ep_datain`, `underrun` and `proto_err` go to 0.
  - FSM goes to IDLE and `ep_ready` goes to 0.
  - A push or pop in the same cycle is discarded.
  - A `clear` mid-block aborts the block.
- Reset values:
  - `ep_ready` = 0, `ep_datain` = 0, `level` = 0, `underrun` = 0, `proto_err` = 0, FSM = IDLE.
  - `s_ready` = 1 (count 0).
  - `rst` asserted mid-block aborts immediately; FIFO contents are don't-care.

## Timing
- Read latency: `ep_datain` is valid on the cycle after `ep_read` is sampled high (okBTPipeOut requirement); back-to-back reads give one word per cycle.
- Push-to-`level` latency: 1 cycle. Push-to-`ep_ready` latency: 1 cycle after the push that brings count to BLOCK_WORDS (both registered from next-state).
- `ep_blockstrobe` precedes the first `ep_read` of a block by ≥1 cycle; `ep_ready` drops on the edge after `ep_blockstrobe` is sampled.
- After the last read of a block, `ep_ready` re-asserts on the following edge if count_next ≥ BLOCK_WORDS.
- Sticky flags set on the edge after the offending strobe and clear only on `rst` or `clear`.
- No combinational path from `ep_read` to any output.

## Test plan
- Reset, then push 16 words 0x100..0x10F -> `ep_ready` 1 one cycle after the 16th push, `level` = 16; blockstrobe then 16 reads -> `ep_datain` = 0x100..0x10F on consecutive cycles, each one cycle after its read, `ep_ready` 0 during XFER, `level` = 0 at end.
- Push 512 words with `s_valid` held high -> `s_ready` 0 after the 512th push, the 513th word is not accepted; one block read -> `s_ready` 1 the cycle after the first pop, `ep_ready` re-asserts after the block.
- Steady push every cycle while the host reads a block -> `level` constant, data order preserved across pointer wrap at 511 -> 0.
- Push 3 words, blockstrobe, 5 reads -> first 3 reads return data, reads 4-5 return 0, `underrun` = 1, `level` = 0.
- `ep_read` with no blockstrobe -> word popped, `proto_err` = 1; then `clear` -> all flags 0, `level` 0, `ep_ready` 0.
- Assert `rst` mid-block after 8 of 16 reads -> outputs return to reset values asynchronously; after release, a fresh 16-word block transfers correctly.
